// File: rtl/mem_responder_pkg.sv
// Shared definitions for the load/store memory responder: funct3 encodings,
// FSM state type and the store byte-enable helper.
package mem_resp_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] mask;
        case (funct3)
            F3_B:    mask = 4'b0001 << off;
            F3_H:    mask = 4'b0011 << off;
            F3_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_responder_load_format.sv
// Combinational load formatter: picks the addressed byte/half of a word and
// produces every sign/zero-extended load candidate at once.
module load_format (
    input  logic [31:0] word,
    input  logic [1:0]  off,
    output logic [31:0] lb,
    output logic [31:0] lh,
    output logic [31:0] lw,
    output logic [31:0] lbu,
    output logic [31:0] lhu
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{off, 3'b000} +: 8];
        sel_half = off[1] ? word[31:16] : word[15:0];
        lb       = {{24{sel_byte[7]}}, sel_byte};
        lbu      = {24'h0, sel_byte};
        lh       = {{16{sel_half[15]}}, sel_half};
        lhu      = {16'h0, sel_half};
        lw       = word;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed programmable latency,
// byte-masked stores and pre-formatted load candidates.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_lb,
    output logic [31:0] resp_lh,
    output logic [31:0] resp_lw,
    output logic [31:0] resp_lbu,
    output logic [31:0] resp_lhu,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        err_q, err_d;
    logic [31:0] lb_q, lb_d, lh_q, lh_d, lw_q, lw_d, lbu_q, lbu_d, lhu_q, lhu_d;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          oor, illegal, misalign, err_c, access, mem_we;
    logic [3:0]    mask;
    logic [31:0]   st_data, rd_word;
    logic [31:0]   fmt_lb, fmt_lh, fmt_lw, fmt_lbu, fmt_lhu;

    always_comb begin
        idx      = addr_q[AW+1:2];
        off      = addr_q[1:0];
        oor      = |addr_q[31:AW+2];
        illegal  = !(f3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                   (we_q && (f3_q inside {F3_BU, F3_HU}));
        misalign = ((f3_q inside {F3_H, F3_HU}) && off[0]) ||
                   ((f3_q == F3_W) && (off != 2'b00));
        err_c    = illegal || misalign || oor;
        mask     = byte_mask(f3_q, off);
        case (f3_q)
            F3_B:    st_data = {4{wdata_q[7:0]}};
            F3_H:    st_data = {2{wdata_q[15:0]}};
            default: st_data = wdata_q;
        endcase
        rd_word  = mem_q[idx];
        access   = (state_q == WAIT) && (cnt_q == '0);
        // rst gates the commit so a store caught by reset is dropped, not half-done
        mem_we   = access && we_q && !err_c && !rst;
    end

    load_format u_load_format (
        .word (rd_word),
        .off  (off),
        .lb   (fmt_lb),
        .lh   (fmt_lh),
        .lw   (fmt_lw),
        .lbu  (fmt_lbu),
        .lhu  (fmt_lhu)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mask[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        err_d        = err_q;
        lb_d         = lb_q;
        lh_d         = lh_q;
        lw_d         = lw_q;
        lbu_d        = lbu_q;
        lhu_d        = lhu_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    f3_d        = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (access) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    err_d        = err_c;
                    if (err_c || we_q) begin
                        lb_d  = '0;
                        lh_d  = '0;
                        lw_d  = '0;
                        lbu_d = '0;
                        lhu_d = '0;
                    end else begin
                        lb_d  = fmt_lb;
                        lh_d  = fmt_lh;
                        lw_d  = fmt_lw;
                        lbu_d = fmt_lbu;
                        lhu_d = fmt_lhu;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            lb_q         <= '0;
            lh_q         <= '0;
            lw_q         <= '0;
            lbu_q        <= '0;
            lhu_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            lb_q         <= lb_d;
            lh_q         <= lh_d;
            lw_q         <= lw_d;
            lbu_q        <= lbu_d;
            lhu_q        <= lhu_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = err_q;
    assign resp_lb    = lb_q;
    assign resp_lh    = lh_q;
    assign resp_lw    = lw_q;
    assign resp_lbu   = lbu_q;
    assign resp_lhu   = lhu_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic compared against a byte-addressed reference memory.
module tb_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_lb, resp_lh, resp_lw, resp_lbu, resp_lhu;
    logic        resp_err;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lb    (resp_lb),
        .resp_lh    (resp_lh),
        .resp_lw    (resp_lw),
        .resp_lbu   (resp_lbu),
        .resp_lhu   (resp_lhu),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_b [4*DEPTH];
    logic [31:0] got_lb, got_lh, got_lw, got_lbu, got_lhu;
    logic        got_err;
    int          got_lat;
    logic [31:0] exp_lb, exp_lh, exp_lw, exp_lbu, exp_lhu;
    logic        exp_err;

    // Reference: memory as a little-endian byte array; legality from access size.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int size, a, base, hb;
        logic legal;
        logic [7:0] b;
        logic [15:0] h;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = 1'b1;
        if (size == 0) legal = 1'b0;
        else if (we && f3[2]) legal = 1'b0;
        else if (addr >= LIMIT) legal = 1'b0;
        else if ((int'(addr) % size) != 0) legal = 1'b0;
        exp_lb = '0; exp_lh = '0; exp_lw = '0; exp_lbu = '0; exp_lhu = '0;
        exp_err = !legal;
        if (legal) begin
            a = int'(addr);
            if (we) begin
                for (int k = 0; k < size; k++) ref_b[a+k] = wd[8*k +: 8];
            end else begin
                base    = a - (a % 4);
                hb      = base + (((a % 4) >= 2) ? 2 : 0);
                b       = ref_b[a];
                h       = {ref_b[hb+1], ref_b[hb]};
                exp_lw  = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
                exp_lbu = 32'(b);
                exp_lhu = 32'(h);
                exp_lb  = b[7] ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
                exp_lh  = h[15] ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
            end
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        int guard;
        guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout got %b need 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got_lat = 0;
        while (resp_valid !== 1'b1 && got_lat < 100) begin
            @(posedge clk); #1;
            got_lat++;
        end
        if (got_lat >= 100) begin
            checks++; errors++;
            $display("FAIL resp_valid_timeout got %b need 1", resp_valid);
        end
        got_lb = resp_lb; got_lh = resp_lh; got_lw = resp_lw;
        got_lbu = resp_lbu; got_lhu = resp_lhu; got_err = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
        model(we, f3, addr, wd);
        xact(we, f3, addr, wd);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b need 1", req_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b need 0", resp_valid); end
        checks++;
        if ({resp_lb, resp_lh, resp_lw, resp_lbu, resp_lhu, resp_err} !== '0) begin
            errors++; $display("FAIL reset_outputs got lw=%h lb=%h err=%b need 0", resp_lw, resp_lb, resp_err);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            run(1'b1, 3'd2, 32'(4 * i), $urandom);
            checks++;
            if (got_err !== 1'b0 || got_lw !== 32'h0) begin
                errors++; $display("FAIL fill_resp idx=%0d got err=%b lw=%h need 0", i, got_err, got_lw);
            end
        end
    endtask

    task automatic test_store_load();
        run(1'b1, 3'd2, 32'h10, 32'h8000_00F0);
        checks++;
        if (got_lat != LATENCY) begin errors++; $display("FAIL store_latency got %0d need %0d", got_lat, LATENCY); end
        run(1'b0, 3'd2, 32'h10, 32'h0);
        checks++;
        if (got_lw !== 32'h8000_00F0) begin errors++; $display("FAIL lw_0x10 got %h need 800000f0", got_lw); end
        checks++;
        if (got_lat != LATENCY) begin errors++; $display("FAIL load_latency got %0d need %0d", got_lat, LATENCY); end
        run(1'b0, 3'd0, 32'h10, 32'h0);
        checks++;
        if (got_lb !== 32'hFFFF_FFF0 || got_lbu !== 32'h0000_00F0) begin
            errors++; $display("FAIL lb_0x10 got lb=%h lbu=%h need fffffff0/000000f0", got_lb, got_lbu);
        end
        run(1'b0, 3'd1, 32'h12, 32'h0);
        checks++;
        if (got_lh !== 32'hFFFF_8000 || got_lhu !== 32'h0000_8000) begin
            errors++; $display("FAIL lh_0x12 got lh=%h lhu=%h need ffff8000/00008000", got_lh, got_lhu);
        end
    endtask

    task automatic test_byte_mask();
        run(1'b1, 3'd2, 32'h20, 32'h1111_1111);
        run(1'b1, 3'd0, 32'h22, 32'h0000_00AB);
        run(1'b0, 3'd2, 32'h20, 32'h0);
        checks++;
        if (got_lw !== 32'h11AB_1111) begin errors++; $display("FAIL sb_mask got %h need 11ab1111", got_lw); end
        run(1'b1, 3'd1, 32'h20, 32'h0000_CDEF);
        run(1'b0, 3'd2, 32'h20, 32'h0);
        checks++;
        if (got_lw !== 32'h11AB_CDEF) begin errors++; $display("FAIL sh_mask got %h need 11abcdef", got_lw); end
    endtask

    task automatic test_errors();
        logic [31:0] old;
        run(1'b0, 3'd2, 32'h21, 32'h0);
        checks++;
        if (got_err !== 1'b1 || {got_lb, got_lh, got_lw, got_lbu, got_lhu} !== '0) begin
            errors++; $display("FAIL misaligned_lw got err=%b lw=%h lb=%h need err=1 zeros", got_err, got_lw, got_lb);
        end
        old = {ref_b[3], ref_b[2], ref_b[1], ref_b[0]};
        run(1'b1, 3'd2, LIMIT, 32'hFFFF_FFFF);
        checks++;
        if (got_err !== 1'b1) begin errors++; $display("FAIL oor_store_err got %b need 1", got_err); end
        run(1'b0, 3'd2, 32'h0, 32'h0);
        checks++;
        if (got_lw !== old) begin errors++; $display("FAIL oor_store_readback got %h need %h", got_lw, old); end
    endtask

    task automatic test_random();
        logic we;
        logic [2:0] f3;
        logic [31:0] addr;
        int r;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r < 7)       addr = 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (r < 9)  addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else             addr = LIMIT * 32'($urandom_range(1, 1000)) + 32'($urandom_range(0, 1023));
            run(we, f3, addr, $urandom);
            checks++;
            if (got_err !== exp_err || got_lw !== exp_lw || got_lb !== exp_lb || got_lh !== exp_lh ||
                got_lbu !== exp_lbu || got_lhu !== exp_lhu) begin
                errors++;
                $display("FAIL rand[%0d] we=%b f3=%0d addr=%h got err=%b lw=%h lb=%h lh=%h lbu=%h lhu=%h need err=%b lw=%h lb=%h lh=%h lbu=%h lhu=%h",
                         i, we, f3, addr, got_err, got_lw, got_lb, got_lh, got_lbu, got_lhu,
                         exp_err, exp_lw, exp_lb, exp_lh, exp_lbu, exp_lhu);
            end
            checks++;
            if (got_lat != LATENCY) begin errors++; $display("FAIL rand_latency[%0d] got %0d need %0d", i, got_lat, LATENCY); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_lw;
        int lat;
        @(negedge clk);
        model(1'b0, 3'd2, 32'h20, 32'h0);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = '0;
        @(posedge clk); #1;
        // second request held pending throughout the stalled response
        req_addr = 32'h10;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        held_lw = resp_lw;
        checks++;
        if (held_lw !== exp_lw) begin errors++; $display("FAIL bp_first_lw got %h need %h", held_lw, exp_lw); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_lw !== held_lw || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b lw=%h ready=%b need 1/%h/0", c, resp_valid, resp_lw, req_ready, held_lw);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%b ready=%b need 0/1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got ready=%b need 0", req_ready); end
        model(1'b0, 3'd2, 32'h10, 32'h0);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != LATENCY || resp_lw !== exp_lw) begin
            errors++; $display("FAIL bp_second got lat=%0d lw=%h need %0d/%h", lat, resp_lw, LATENCY, exp_lw);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] old;
        old = {ref_b[32'h33], ref_b[32'h32], ref_b[32'h31], ref_b[32'h30]};
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got ready=%b valid=%b need 1/0", req_ready, resp_valid);
        end
        run(1'b0, 3'd2, 32'h30, 32'h0);
        checks++;
        if (got_lw !== old || got_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset_readback got %h err=%b need %h err=0", got_lw, got_err, old);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_byte_mask();
        test_errors();
        test_random();
        test_backpressure();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
